// File: rtl/id_operand_stage.sv
// Operand-fetch stage between decode and execute: register file read, EX/MEM/WB
// forwarding, operand hazard detection and a one-entry valid/ready slot feeding EX.
module id_operand_stage #(
  parameter int XLEN  = 64,
  parameter int AW    = 5,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [XLEN-1:0]  in_pc,
  input  logic [XLEN-1:0]  in_imm,
  input  logic             in_rs1_en,
  input  logic             in_rs2_en,
  input  logic [AW-1:0]    in_rs1_addr,
  input  logic [AW-1:0]    in_rs2_addr,
  input  logic             in_rd_en,
  input  logic [AW-1:0]    in_rd_addr,
  input  logic             in_is_load,
  output logic             rs1_en,
  output logic             rs2_en,
  output logic [AW-1:0]    rs1_addr,
  output logic [AW-1:0]    rs2_addr,
  input  logic [XLEN-1:0]  rs1_data,
  input  logic [XLEN-1:0]  rs2_data,
  input  logic             ex_fwd_en,
  input  logic [AW-1:0]    ex_fwd_addr,
  input  logic [XLEN-1:0]  ex_fwd_data,
  input  logic             ex_is_load,
  input  logic             mem_fwd_en,
  input  logic [AW-1:0]    mem_fwd_addr,
  input  logic [XLEN-1:0]  mem_fwd_data,
  input  logic             wb_en,
  input  logic [AW-1:0]    wb_addr,
  input  logic [XLEN-1:0]  wb_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_pc,
  output logic [XLEN-1:0]  out_imm,
  output logic [XLEN-1:0]  out_rs1_val,
  output logic [XLEN-1:0]  out_rs2_val,
  output logic             out_rd_en,
  output logic [AW-1:0]    out_rd_addr,
  output logic             out_is_load,
  output logic [CNT_W-1:0] stall_cnt
);

  logic [XLEN-1:0] src1_val;
  logic [XLEN-1:0] src2_val;
  logic            haz1;
  logic            haz2;
  logic            stall;
  logic            accept;

  assign rs1_en   = in_rs1_en;
  assign rs2_en   = in_rs2_en;
  assign rs1_addr = in_rs1_addr;
  assign rs2_addr = in_rs2_addr;

  // Youngest producer wins; a load in EX has no data yet, so it is never forwarded.
  function automatic logic [XLEN-1:0] select_src(input logic en, input logic [AW-1:0] a,
                                                  input logic [XLEN-1:0] rf_data);
    logic [XLEN-1:0] v;
    v = rf_data;
    if (!en || a == '0)                                  v = '0;
    else if (ex_fwd_en && ex_fwd_addr == a && !ex_is_load) v = ex_fwd_data;
    else if (mem_fwd_en && mem_fwd_addr == a)            v = mem_fwd_data;
    else if (wb_en && wb_addr == a)                      v = wb_data;
    return v;
  endfunction

  function automatic logic src_hazard(input logic en, input logic [AW-1:0] a);
    logic h;
    h = 1'b0;
    if (en && a != '0) begin
      h = (out_valid && out_rd_en && out_rd_addr == a) ||
          (ex_fwd_en && ex_is_load && ex_fwd_addr == a);
    end
    return h;
  endfunction

  always_comb begin
    src1_val = select_src(in_rs1_en, in_rs1_addr, rs1_data);
    src2_val = select_src(in_rs2_en, in_rs2_addr, rs2_data);
    haz1     = src_hazard(in_rs1_en, in_rs1_addr);
    haz2     = src_hazard(in_rs2_en, in_rs2_addr);
    stall    = in_valid && (haz1 || haz2);
    in_ready = !rst && !flush && !stall && (!out_valid || out_ready);
    accept   = in_valid && in_ready;
  end

  // Back-pressure cycles count as stalls too; flushed cycles do not.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid   <= 1'b0;
      out_pc      <= '0;
      out_imm     <= '0;
      out_rs1_val <= '0;
      out_rs2_val <= '0;
      out_rd_en   <= 1'b0;
      out_rd_addr <= '0;
      out_is_load <= 1'b0;
      stall_cnt   <= '0;
    end else begin
      if (flush) begin
        out_valid <= 1'b0;
      end else if (accept) begin
        out_valid   <= 1'b1;
        out_pc      <= in_pc;
        out_imm     <= in_imm;
        out_rs1_val <= src1_val;
        out_rs2_val <= src2_val;
        out_rd_en   <= in_rd_en;
        out_rd_addr <= in_rd_addr;
        out_is_load <= in_is_load;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (in_valid && !in_ready && !flush) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_id_operand_stage.sv
// Scoreboard bench for id_operand_stage: the bench plays EX/MEM/WB and the register
// file, and expects every operand to equal the architectural register value in program order.
module tb_id_operand_stage;
  localparam int XLEN = 64, AW = 5, CNT_W = 32;

  logic clk;
  logic rst, flush, in_valid, in_ready;
  logic [XLEN-1:0] in_pc, in_imm;
  logic in_rs1_en, in_rs2_en, in_rd_en, in_is_load;
  logic [AW-1:0] in_rs1_addr, in_rs2_addr, in_rd_addr;
  logic rs1_en, rs2_en;
  logic [AW-1:0] rs1_addr, rs2_addr;
  logic [XLEN-1:0] rs1_data, rs2_data;
  logic ex_fwd_en, ex_is_load, mem_fwd_en, wb_en;
  logic [AW-1:0] ex_fwd_addr, mem_fwd_addr, wb_addr;
  logic [XLEN-1:0] ex_fwd_data, mem_fwd_data, wb_data;
  logic out_valid, out_ready, out_rd_en, out_is_load;
  logic [XLEN-1:0] out_pc, out_imm, out_rs1_val, out_rs2_val;
  logic [AW-1:0] out_rd_addr;
  logic [CNT_W-1:0] stall_cnt;

  id_operand_stage #(.XLEN(XLEN), .AW(AW), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_imm(in_imm), .in_rs1_en(in_rs1_en), .in_rs2_en(in_rs2_en),
    .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr), .in_rd_en(in_rd_en),
    .in_rd_addr(in_rd_addr), .in_is_load(in_is_load), .rs1_en(rs1_en), .rs2_en(rs2_en),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .ex_fwd_en(ex_fwd_en), .ex_fwd_addr(ex_fwd_addr), .ex_fwd_data(ex_fwd_data),
    .ex_is_load(ex_is_load), .mem_fwd_en(mem_fwd_en), .mem_fwd_addr(mem_fwd_addr),
    .mem_fwd_data(mem_fwd_data), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_imm(out_imm),
    .out_rs1_val(out_rs1_val), .out_rs2_val(out_rs2_val), .out_rd_en(out_rd_en),
    .out_rd_addr(out_rd_addr), .out_is_load(out_is_load), .stall_cnt(stall_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct { logic [63:0] pc, imm, rs1v, rs2v; logic [6:0] dst; } exp_t;
  typedef struct { logic v; logic [4:0] rd; logic ld; logic [63:0] res; } stage_t;

  exp_t        exp_q[$];
  stage_t      ex_s, mem_s, wb_s;
  logic [63:0] rf      [0:31];
  logic [63:0] arch    [0:31];
  logic [63:0] res_tab [0:4095];
  int          next_pc;
  int          checks_total, checks_passed;
  bit          track;
  int          or_mode;   // 0: out_ready always 1, 1: random, 2: left as driven
  bit          last_acc;

  assign rs1_data = rf[rs1_addr];
  assign rs2_data = rf[rs2_addr];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks_total++;
    if (act === expv) checks_passed++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
  endtask

  task automatic drive_stages();
    ex_fwd_en    = ex_s.v;
    ex_fwd_addr  = ex_s.rd;
    ex_fwd_data  = ex_s.ld ? {$urandom, $urandom} : ex_s.res;
    ex_is_load   = ex_s.v && ex_s.ld;
    mem_fwd_en   = mem_s.v;
    mem_fwd_addr = mem_s.rd;
    mem_fwd_data = mem_s.res;
    wb_en        = wb_s.v;
    wb_addr      = wb_s.rd;
    wb_data      = wb_s.res;
  endtask

  // One clock: sample at the falling edge, then advance the downstream pipeline after the rise.
  task automatic step();
    bit cons, was_rst;
    logic s_rd_en, s_ld;
    logic [4:0] s_rd;
    logic [63:0] s_pc;
    @(negedge clk);
    was_rst  = rst;
    last_acc = in_valid && in_ready;
    cons     = out_valid && out_ready && !flush && !rst;
    s_rd_en  = out_rd_en;
    s_rd     = out_rd_addr;
    s_ld     = out_is_load;
    s_pc     = out_pc;
    @(posedge clk);
    #1;
    if (wb_s.v && wb_s.rd != 5'd0) rf[wb_s.rd] = wb_s.res;
    wb_s     = mem_s;
    mem_s    = ex_s;
    ex_s.v   = cons && s_rd_en;
    ex_s.rd  = s_rd;
    ex_s.ld  = s_ld;
    ex_s.res = res_tab[s_pc[11:0]];
    if (was_rst) begin
      ex_s.v = 1'b0; mem_s.v = 1'b0; wb_s.v = 1'b0;
    end
    drive_stages();
    if (or_mode == 0) out_ready = 1'b1;
    else if (or_mode == 1) out_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic applyStimulus(input bit r1e, input logic [4:0] r1, input bit r2e,
                               input logic [4:0] r2, input bit rde, input logic [4:0] rd,
                               input bit ld, input logic [63:0] res);
    exp_t e;
    e.pc   = 64'(next_pc);
    e.imm  = {$urandom, $urandom};
    e.rs1v = (r1e && r1 != 5'd0) ? arch[r1] : 64'd0;
    e.rs2v = (r2e && r2 != 5'd0) ? arch[r2] : 64'd0;
    e.dst  = {rde, rd, ld};
    if (track) begin
      exp_q.push_back(e);
      if (rde && rd != 5'd0) arch[rd] = res;
    end
    res_tab[next_pc] = res;
    in_pc = e.pc;        in_imm = e.imm;
    in_rs1_en = r1e;     in_rs1_addr = r1;
    in_rs2_en = r2e;     in_rs2_addr = r2;
    in_rd_en = rde;      in_rd_addr = rd;   in_is_load = ld;
    in_valid = 1'b1;
    next_pc++;
  endtask

  task automatic wait_accept(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!last_acc && n < 100);
    check("accepted", 64'(last_acc), 64'd1);
    in_valid = 1'b0;
  endtask

  task automatic issue(input bit r1e, input logic [4:0] r1, input bit r2e, input logic [4:0] r2,
                       input bit rde, input logic [4:0] rd, input bit ld, input logic [63:0] res,
                       output int n);
    applyStimulus(r1e, r1, r2e, r2, rde, rd, ld, res);
    wait_accept(n);
  endtask

  task automatic drain();
    in_valid = 1'b0;
    repeat (6) step();
    #1;
  endtask

  task automatic checkOutput();
    exp_t e;
    checks_total++;
    if (exp_q.size() == 0) begin
      $display("[TB] FAIL unexpected_output: got pc 0x%0h, expected no output", out_pc);
      return;
    end
    checks_passed++;
    e = exp_q.pop_front();
    check("out_pc", out_pc, e.pc);
    check("out_imm", out_imm, e.imm);
    check("out_rs1_val", out_rs1_val, e.rs1v);
    check("out_rs2_val", out_rs2_val, e.rs2v);
    check("out_dst", 64'({out_rd_en, out_rd_addr, out_is_load}), 64'(e.dst));
  endtask

  // Monitor: scores every consumed slot and checks that a stalled slot stays put.
  initial begin
    bit held;
    logic [63:0] h_pc, h_r1, h_r2;
    held = 1'b0;
    forever begin
      @(negedge clk);
      if (held) begin
        check("hold_valid", 64'(out_valid), 64'd1);
        check("hold_pc", out_pc, h_pc);
        check("hold_rs1", out_rs1_val, h_r1);
        check("hold_rs2", out_rs2_val, h_r2);
      end
      if (!rst && !flush && out_valid && out_ready && track) checkOutput();
      held = out_valid && !out_ready && !flush && !rst;
      h_pc = out_pc; h_r1 = out_rs1_val; h_r2 = out_rs2_val;
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n, steps;
    checks_total = 0; checks_passed = 0; next_pc = 0; track = 1'b1; or_mode = 0;
    for (int k = 0; k < 32; k++) rf[k] = {$urandom, $urandom};
    rf[0] = 64'hBAD; rf[1] = 64'h11; rf[2] = 64'h22; rf[3] = 64'h0;
    for (int k = 0; k < 32; k++) arch[k] = rf[k];
    arch[0] = 64'd0;
    ex_s = '{default: '0}; mem_s = '{default: '0}; wb_s = '{default: '0};
    drive_stages();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_pc = '0; in_imm = '0; in_rs1_en = 0; in_rs2_en = 0; in_rs1_addr = '0;
    in_rs2_addr = '0; in_rd_en = 0; in_rd_addr = '0; in_is_load = 0;

    step(); step(); #1;
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_out_pc", out_pc, 64'd0);
    check("reset_out_rs1", out_rs1_val, 64'd0);
    check("reset_stall_cnt", 64'(stall_cnt), 64'd0);
    check("reset_in_ready", 64'(in_ready), 64'd0);
    rst = 1'b0;

    $display("[TB] independent stream");
    steps = 0;
    repeat (4) begin
      issue(1, 5'd1, 1, 5'd2, 0, 5'd0, 0, {$urandom, $urandom}, n);
      steps += n;
    end
    check("indep_cycles", 64'(steps), 64'd4);
    drain();
    check("indep_stall_cnt", 64'(stall_cnt), 64'd0);

    $display("[TB] ALU dependency");
    issue(0, 5'd0, 0, 5'd0, 1, 5'd5, 0, 64'hDEAD, n);
    issue(1, 5'd5, 0, 5'd0, 1, 5'd6, 0, {$urandom, $urandom}, n);
    check("alu_dep_cycles", 64'(n), 64'd2);
    drain();
    check("alu_dep_stall_cnt", 64'(stall_cnt), 64'd1);

    $display("[TB] load-use");
    issue(0, 5'd0, 0, 5'd0, 1, 5'd7, 1, 64'hBEEF, n);
    issue(1, 5'd7, 1, 5'd1, 1, 5'd8, 0, {$urandom, $urandom}, n);
    check("load_use_cycles", 64'(n), 64'd3);
    drain();
    check("load_use_stall_cnt", 64'(stall_cnt), 64'd3);

    $display("[TB] WB bypass and x0");
    issue(0, 5'd0, 0, 5'd0, 1, 5'd3, 0, 64'h55, n);
    repeat (3) issue(0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 64'd0, n);
    issue(1, 5'd3, 0, 5'd0, 0, 5'd0, 0, 64'd0, n);
    issue(0, 5'd0, 0, 5'd0, 1, 5'd0, 0, 64'h77, n);
    issue(0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 64'd0, n);
    issue(1, 5'd0, 1, 5'd0, 0, 5'd0, 0, 64'd0, n);
    drain();
    check("wb_x0_stall_cnt", 64'(stall_cnt), 64'd3);

    $display("[TB] back-pressure");
    or_mode = 2; out_ready = 1'b1;
    issue(1, 5'd1, 1, 5'd2, 0, 5'd0, 0, 64'd0, n);
    out_ready = 1'b0;
    applyStimulus(1, 5'd2, 0, 5'd0, 0, 5'd0, 0, 64'd0);
    repeat (3) begin
      step();
      check("bp_in_ready", 64'(last_acc), 64'd0);
    end
    out_ready = 1'b1;
    wait_accept(n);
    check("bp_release_cycles", 64'(n), 64'd1);
    or_mode = 0;
    drain();
    check("bp_stall_cnt", 64'(stall_cnt), 64'd6);

    $display("[TB] flush");
    track = 1'b0; or_mode = 2; out_ready = 1'b0;
    issue(1, 5'd1, 0, 5'd0, 0, 5'd0, 0, 64'd0, n);
    applyStimulus(1, 5'd2, 0, 5'd0, 0, 5'd0, 0, 64'd0);
    flush = 1'b1;
    #1;
    check("flush_in_ready", 64'(in_ready), 64'd0);
    step();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    #1;
    check("flush_out_valid", 64'(out_valid), 64'd0);
    step(); #1;
    check("flush_no_accept", 64'(out_valid), 64'd0);
    check("flush_stall_cnt", 64'(stall_cnt), 64'd6);
    track = 1'b1; or_mode = 0;

    $display("[TB] random stream");
    or_mode = 1;
    repeat (300) begin
      if ($urandom_range(0, 4) == 0) begin
        in_valid = 1'b0;
        repeat ($urandom_range(1, 3)) step();
      end
      issue($urandom_range(0, 5) != 0, 5'($urandom_range(0, 7)),
            $urandom_range(0, 5) != 0, 5'($urandom_range(0, 7)),
            $urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)),
            $urandom_range(0, 2) == 0, {$urandom, $urandom}, n);
    end
    or_mode = 0;
    drain();
    check("scoreboard_drain", 64'(exp_q.size()), 64'd0);

    $display("[TB] reset mid-stream");
    track = 1'b0; or_mode = 2; out_ready = 1'b0;
    issue(1, 5'd1, 1, 5'd2, 0, 5'd0, 0, 64'd0, n);
    applyStimulus(1, 5'd1, 0, 5'd0, 0, 5'd0, 0, 64'd0);
    step();
    rst = 1'b1;
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd0);
    step(); #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_rs1", out_rs1_val, 64'd0);
    check("rst_out_pc", out_pc, 64'd0);
    check("rst_stall_cnt", 64'(stall_cnt), 64'd0);
    rst = 1'b0; in_valid = 1'b0;

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
